// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - shared types and constants for the jump predictor sequencer
package jump_pkg;

    localparam int ADR_W = 16;

    // Next-PC mux source encoding
    typedef enum logic [1:0] {
        PCSEL_INC  = 2'd0,
        PCSEL_PRED = 2'd1,
        PCSEL_ALU  = 2'd2,
        PCSEL_EVAC = 2'd3
    } pc_sel_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRED      = 2'd1,
        RECOV_ADR = 2'd2,
        RECOV_NT  = 2'd3
    } jctl_state_t;

endpackage

// File: rtl/jump_ctrl_cnt.sv
// rtl/jump_ctrl_cnt.sv - saturating event counter with enable
module jump_ctrl_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// rtl/jump_ctrl.sv - single-entry jump prediction sequencer; JUMP_CTRL_PERF_EN enables hit/miss counters
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jump_pred,
    input  logic [ADR_W-1:0] jump_pred_adr,
    input  logic [ADR_W-1:0] pcinc_evac,
    input  logic             jump_resolve,
    input  logic             jump_taken,
    input  logic [ADR_W-1:0] ALUres_mem,
    input  logic             stall,
    output logic [1:0]       pc_sel,
    output logic [ADR_W-1:0] pc_next_alt,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             pred_busy,
    output logic             wd_err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    jctl_state_t      state_q, state_d;
    logic [ADR_W-1:0] tgt_q, tgt_d;    // predicted target, reused for the actual target on address miss
    logic [ADR_W-1:0] evac_q, evac_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic             wd_q, wd_d;
    pc_sel_t          sel;
    logic [ADR_W-1:0] alt;
    logic             flush;
    logic             busy;
`ifdef JUMP_CTRL_PERF_EN
    logic             hit_ev;
    logic             miss_ev;
`endif

    // Next-state, latch updates and Moore/Mealy outputs
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        evac_d  = evac_q;
        wait_d  = wait_q;
        wd_d    = wd_q;
        sel     = PCSEL_INC;
        alt     = '0;
        flush   = 1'b0;
        busy    = 1'b0;
`ifdef JUMP_CTRL_PERF_EN
        hit_ev  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!stall) begin
                    // An unpredicted taken jump in MEM overrides a prediction in ID,
                    // since the ID instruction is on the wrong path.
                    if (jump_resolve && jump_taken) begin
                        tgt_d   = ALUres_mem;
                        state_d = RECOV_ADR;
                    end else if (jump_pred) begin
                        sel     = PCSEL_PRED;
                        alt     = jump_pred_adr;
                        tgt_d   = jump_pred_adr;
                        evac_d  = pcinc_evac;
                        wait_d  = '0;
                        state_d = PRED;
                    end
                end
            end
            PRED: begin
                busy = 1'b1;
                if (!stall) begin
                    if (jump_resolve) begin
                        if (jump_taken && (ALUres_mem == tgt_q)) begin
`ifdef JUMP_CTRL_PERF_EN
                            hit_ev = 1'b1;
`endif
                            if (jump_pred) begin
                                sel    = PCSEL_PRED;
                                alt    = jump_pred_adr;
                                tgt_d  = jump_pred_adr;
                                evac_d = pcinc_evac;
                                wait_d = '0;
                            end else begin
                                state_d = IDLE;
                            end
                        end else if (jump_taken) begin
                            tgt_d   = ALUres_mem;
                            state_d = RECOV_ADR;
                        end else begin
                            state_d = RECOV_NT;
                        end
                    end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                        wd_d    = 1'b1;
                        state_d = RECOV_NT;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            RECOV_ADR: begin
                sel   = PCSEL_ALU;
                alt   = tgt_q;
                flush = 1'b1;
                busy  = 1'b1;
                if (!stall) state_d = IDLE;
            end
            default: begin
                sel   = PCSEL_EVAC;
                alt   = evac_q;
                flush = 1'b1;
                busy  = 1'b1;
                if (!stall) state_d = IDLE;
            end
        endcase
    end

    // State, latched addresses, watchdog counter and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            evac_q  <= '0;
            wait_q  <= '0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            evac_q  <= evac_d;
            wait_q  <= wait_d;
            wd_q    <= wd_d;
        end
    end

    // Outputs are forced quiet while reset is held so an aborted recovery never leaks
    assign pc_sel      = reset ? PCSEL_INC : sel;
    assign pc_next_alt = reset ? '0 : alt;
    assign flush_if    = flush && !reset;
    assign flush_id    = flush && !reset;
    assign flush_ex    = flush && !reset;
    assign pred_busy   = busy && !reset;
    assign wd_err      = wd_q;

`ifdef JUMP_CTRL_PERF_EN
    // Recovery states always return to IDLE, so any transition into one is a fresh miss
    assign miss_ev = ((state_d == RECOV_ADR) || (state_d == RECOV_NT)) &&
                     (state_q != RECOV_ADR) && (state_q != RECOV_NT);

    jump_ctrl_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (hit_ev),
        .count (hit_cnt)
    );

    jump_ctrl_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (miss_ev),
        .count (miss_cnt)
    );
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_jump_ctrl.sv
// tb/tb_jump_ctrl.sv - directed self-checking bench for jump_ctrl
module tb_jump_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        jump_pred;
    logic [15:0] jump_pred_adr;
    logic [15:0] pcinc_evac;
    logic        jump_resolve;
    logic        jump_taken;
    logic [15:0] ALUres_mem;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [15:0] pc_next_alt;
    logic        flush_if, flush_id, flush_ex;
    logic        pred_busy;
    logic        wd_err;
    logic [15:0] hit_cnt, miss_cnt;

    int checks = 0;
    int fails  = 0;
    logic        wd_exp  = 1'b0;
    logic [15:0] hit_exp = 16'd0;
    logic [15:0] mis_exp = 16'd0;

    always #5 clk = ~clk;

    jump_ctrl #(.MAX_WAIT(4), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .jump_pred     (jump_pred),
        .jump_pred_adr (jump_pred_adr),
        .pcinc_evac    (pcinc_evac),
        .jump_resolve  (jump_resolve),
        .jump_taken    (jump_taken),
        .ALUres_mem    (ALUres_mem),
        .stall         (stall),
        .pc_sel        (pc_sel),
        .pc_next_alt   (pc_next_alt),
        .flush_if      (flush_if),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex),
        .pred_busy     (pred_busy),
        .wd_err        (wd_err),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    wire [22:0] obs = {pc_sel, pc_next_alt, flush_if, flush_id, flush_ex, pred_busy, wd_err};

    function automatic logic [22:0] ev(input logic [1:0] s, input logic [15:0] a,
                                       input logic f, input logic b, input logic w);
        return {s, a, f, f, f, b, w};
    endfunction

    task automatic drive(input logic p, input logic [15:0] padr, input logic [15:0] evac,
                         input logic r, input logic t, input logic [15:0] alu, input logic st);
        jump_pred = p; jump_pred_adr = padr; pcinc_evac = evac;
        jump_resolve = r; jump_taken = t; ALUres_mem = alu; stall = st;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 16'h9abc, 1'b0);
        tick;
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0)) begin $display("FAIL reset_during: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0)); fails++; end
        tick; reset = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0)) begin $display("FAIL reset_after: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0)); fails++; end
        checks++;
        if ({hit_cnt, miss_cnt} !== 32'h0) begin $display("FAIL reset_cnt: got %h want 0", {hit_cnt, miss_cnt}); fails++; end
        tick;
    endtask

    task automatic test_hit;
        drive(1'b1, 16'h0040, 16'h0011, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd1, 16'h0040, 1'b0, 1'b0, wd_exp)) begin $display("FAIL hit_pred: got %h want %h", obs, ev(2'd1, 16'h0040, 1'b0, 1'b0, wd_exp)); fails++; end
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b1, wd_exp)) begin $display("FAIL hit_wait: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b1, wd_exp)); fails++; end
        tick; drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b1, wd_exp)) begin $display("FAIL hit_resolve: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b1, wd_exp)); fails++; end
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
`ifdef JUMP_CTRL_PERF_EN
        hit_exp = hit_exp + 1;
`endif
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)) begin $display("FAIL hit_idle: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)); fails++; end
        checks++;
        if (hit_cnt !== hit_exp) begin $display("FAIL hit_cnt: got %0d want %0d", hit_cnt, hit_exp); fails++; end
        tick;
    endtask

    task automatic test_addr_miss;
        drive(1'b1, 16'h0040, 16'h0011, 1'b0, 1'b0, 16'h0, 1'b0);
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick; drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0080, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b1, wd_exp)) begin $display("FAIL miss_resolve: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b1, wd_exp)); fails++; end
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
`ifdef JUMP_CTRL_PERF_EN
        mis_exp = mis_exp + 1;
`endif
        @(negedge clk); checks++;
        if (obs !== ev(2'd2, 16'h0080, 1'b1, 1'b1, wd_exp)) begin $display("FAIL miss_recov: got %h want %h", obs, ev(2'd2, 16'h0080, 1'b1, 1'b1, wd_exp)); fails++; end
        checks++;
        if (miss_cnt !== mis_exp) begin $display("FAIL miss_cnt: got %0d want %0d", miss_cnt, mis_exp); fails++; end
        tick;
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)) begin $display("FAIL miss_idle: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)); fails++; end
        tick;
    endtask

    task automatic test_not_taken;
        drive(1'b1, 16'h0040, 16'h0011, 1'b0, 1'b0, 16'h0, 1'b0);
        tick; drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0040, 1'b0);
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
`ifdef JUMP_CTRL_PERF_EN
        mis_exp = mis_exp + 1;
`endif
        @(negedge clk); checks++;
        if (obs !== ev(2'd3, 16'h0011, 1'b1, 1'b1, wd_exp)) begin $display("FAIL nt_recov: got %h want %h", obs, ev(2'd3, 16'h0011, 1'b1, 1'b1, wd_exp)); fails++; end
        tick;
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)) begin $display("FAIL nt_idle: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)); fails++; end
        tick;
    endtask

    task automatic test_stall_recov;
        drive(1'b1, 16'h0200, 16'h0022, 1'b0, 1'b0, 16'h0, 1'b0);
        tick; drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        tick;
`ifdef JUMP_CTRL_PERF_EN
        mis_exp = mis_exp + 1;
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0300, 16'h0033, 1'b0, 1'b0, 16'h0, (i < 3));
            @(negedge clk); checks++;
            if (obs !== ev(2'd3, 16'h0022, 1'b1, 1'b1, wd_exp)) begin $display("FAIL stall_hold%0d: got %h want %h", i, obs, ev(2'd3, 16'h0022, 1'b1, 1'b1, wd_exp)); fails++; end
            tick;
        end
        // Back in IDLE; a stalled prediction must not be accepted
        drive(1'b1, 16'h0300, 16'h0033, 1'b0, 1'b0, 16'h0, 1'b1);
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)) begin $display("FAIL stall_idle_pred: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)); fails++; end
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)) begin $display("FAIL stall_idle_after: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, wd_exp)); fails++; end
        checks++;
        if (miss_cnt !== mis_exp) begin $display("FAIL stall_miss_cnt: got %0d want %0d", miss_cnt, mis_exp); fails++; end
        tick;
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 16'h0040, 16'h0011, 1'b0, 1'b0, 16'h0, 1'b0);
        tick; drive(1'b1, 16'h0100, 16'h0104, 1'b1, 1'b1, 16'h0040, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd1, 16'h0100, 1'b0, 1'b1, wd_exp)) begin $display("FAIL b2b_repred: got %h want %h", obs, ev(2'd1, 16'h0100, 1'b0, 1'b1, wd_exp)); fails++; end
        tick;
`ifdef JUMP_CTRL_PERF_EN
        hit_exp = hit_exp + 1;
`endif
        for (int i = 0; i < 4; i++) begin
            // A lone prediction while one is outstanding is ignored
            drive((i == 1), 16'h0500, 16'h0555, 1'b0, 1'b0, 16'h0, 1'b0);
            @(negedge clk); checks++;
            if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b1, 1'b0)) begin $display("FAIL wd_wait%0d: got %h want %h", i, obs, ev(2'd0, 16'h0, 1'b0, 1'b1, 1'b0)); fails++; end
            tick;
        end
        wd_exp = 1'b1;
`ifdef JUMP_CTRL_PERF_EN
        mis_exp = mis_exp + 1;
`endif
        drive(1'b1, 16'h0600, 16'h0666, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd3, 16'h0104, 1'b1, 1'b1, 1'b1)) begin $display("FAIL wd_recov: got %h want %h", obs, ev(2'd3, 16'h0104, 1'b1, 1'b1, 1'b1)); fails++; end
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b1)) begin $display("FAIL wd_idle: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b1)); fails++; end
        checks++;
        if ({hit_cnt, miss_cnt} !== {hit_exp, mis_exp}) begin $display("FAIL wd_cnts: got %h want %h", {hit_cnt, miss_cnt}, {hit_exp, mis_exp}); fails++; end
        tick;
    endtask

    task automatic test_reset_recov;
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0123, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b1)) begin $display("FAIL unpred_resolve: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b1)); fails++; end
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== ev(2'd2, 16'h0123, 1'b1, 1'b1, 1'b1)) begin $display("FAIL unpred_recov: got %h want %h", obs, ev(2'd2, 16'h0123, 1'b1, 1'b1, 1'b1)); fails++; end
        tick;
        // Second unpredicted jump, then reset lands while in RECOV_ADR
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0456, 1'b0);
        tick; drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        reset = 1'b1;
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b1)) begin $display("FAIL rst_recov_during: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b1)); fails++; end
        tick; reset = 1'b0;
        wd_exp = 1'b0; hit_exp = 16'd0; mis_exp = 16'd0;
        @(negedge clk); checks++;
        if (obs !== ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0)) begin $display("FAIL rst_recov_after: got %h want %h", obs, ev(2'd0, 16'h0, 1'b0, 1'b0, 1'b0)); fails++; end
        checks++;
        if ({hit_cnt, miss_cnt} !== 32'h0) begin $display("FAIL rst_recov_cnt: got %h want 0", {hit_cnt, miss_cnt}); fails++; end
        tick;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick;
        test_reset;
        test_hit;
        test_addr_miss;
        test_not_taken;
        test_stall_recov;
        test_back_to_back;
        test_reset_recov;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Sequencer for the single-entry jump predictor. Tracks the one outstanding predicted jump from ID to MEM and selects the next-PC source.
- Issues pipeline flushes on misprediction and restores the evacuated fall-through PC.
- Sits between the predictor, the PC register mux and the IF/ID/EX pipeline registers.

Parameters:
- MAX_WAIT, 4: non-stalled cycles allowed from prediction to resolve before the watchdog fires.
- CNT_W, 16: width of the performance counters (only used with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- jump_pred  in  1  predictor issues a prediction for the ID instruction this cycle
- jump_pred_adr  in  16  predicted target address
- pcinc_evac  in  16  saved fall-through PC of the predicted instruction
- jump_resolve  in  1  jump instruction resolves in MEM this cycle
- jump_taken  in  1  resolved jump is actually taken
- ALUres_mem  in  16  actual jump target from MEM
- stall  in  1  global pipeline stall
- pc_sel  out  2  next-PC source: 0 = pcinc, 1 = predicted, 2 = ALUres_mem, 3 = pcinc_evac
- pc_next_alt  out  16  address for pc_sel 1/2/3 (0 when pc_sel = 0)
- flush_if, flush_id, flush_ex  out  1 each  kill the contents of those stages
- pred_busy  out  1  a prediction is outstanding
- wd_err  out  1  sticky watchdog error
- hit_cnt, miss_cnt  out  CNT_W each  optional performance counters

Behaviour:
- Reset: state IDLE; wait counter 0; wd_err 0; counters 0.
- Outputs during and right after reset: pc_sel = 0, pc_next_alt = 0, all flushes 0, pred_busy = 0.
- States: IDLE, PRED, RECOV_ADR, RECOV_NT. Outputs are combinational from state and inputs; state and the latched target are registered.
- IDLE:
  - jump_pred → pc_sel = 1, pc_next_alt = jump_pred_adr; latch the target and pcinc_evac; next state PRED.
  - jump_resolve & jump_taken (unpredicted jump) → next state RECOV_ADR with ALUres_mem latched.
  - jump_resolve & !jump_taken → no action.
- PRED:
  - pred_busy = 1.
  - Wait counter increments on each non-stalled cycle.
  - On jump_resolve:
    - taken & ALUres_mem == latched target: hit; go to IDLE. If jump_pred is also high in that cycle, accept it instead: pc_sel = 1, relatch, stay in PRED, counter reset to 0.
    - taken & mismatch: go to RECOV_ADR, latch ALUres_mem.
    - not taken: go to RECOV_NT.
  - A jump_pred arriving in PRED without a resolve in the same cycle is ignored.
- RECOV_ADR: pc_sel = 2, pc_next_alt = latched ALUres_mem, flush_if = flush_id = flush_ex = 1, pred_busy = 1; go to IDLE.
- RECOV_NT: pc_sel = 3, pc_next_alt = latched pcinc_evac, all three flushes = 1, pred_busy = 1; go to IDLE.
- Any jump_pred seen in a recovery state is ignored, because its instruction is flushed.
- Stall:
  - State, latches and counter hold.
  - In recovery states the outputs stay asserted until the first non-stalled cycle, then the state advances.
  - In IDLE with stall, jump_pred is not accepted and pc_sel = 0.
- Watchdog: the counter reaching MAX_WAIT in PRED sets wd_err (sticky until reset) and forces RECOV_NT.
- Address compare is full 16-bit equality. No arithmetic on addresses.
- Reset mid-recovery aborts it: the next cycle is IDLE with all outputs zero.

Optional Feature:
- JUMP_CTRL_PERF_EN defined:
  - hit_cnt increments on each PRED hit.
  - miss_cnt increments on each entry to RECOV_ADR or RECOV_NT, including unpredicted and watchdog cases.
  - Both counters saturate at all-ones.
- Not defined: hit_cnt and miss_cnt are tied to 0 and no counter flops exist.

Decomposition:
- Package jump_pkg:
  - pc_sel enum constants PCSEL_INC = 0, PCSEL_PRED = 1, PCSEL_ALU = 2, PCSEL_EVAC = 3.
  - State enum jctl_state_t.
  - ADR_W = 16.
- One sub-module: jump_ctrl_cnt, a saturating CNT_W counter with enable, instantiated twice under the macro.

Test Plan:
- Hit: jump_pred with adr = 0x0040, resolve taken with ALUres_mem = 0x0040 two cycles later → pc_sel = 1 for one cycle, no flush, IDLE after, hit_cnt = 1.
- Address miss: predicted 0x0040, resolve taken with 0x0080 → next cycle pc_sel = 2, pc_next_alt = 0x0080, all flushes = 1 for exactly one cycle, miss_cnt = 1.
- Not taken: pcinc_evac = 0x0011, resolve not taken → pc_sel = 3, pc_next_alt = 0x0011, flushes = 1 for one cycle.
- Stall in RECOV_NT held 3 cycles → outputs held for 4 cycles total, then IDLE.
- Hit with simultaneous jump_pred 0x0100 → stays PRED, pc_sel = 1 with 0x0100. No resolve within 4 cycles → wd_err = 1, RECOV_NT entered.
- Reset asserted while in RECOV_ADR → next cycle pc_sel = 0, no flushes, pred_busy = 0, counters = 0.
